// File: rtl/brick_pkg.sv
// Shared types and constants for the brick field: cell states, hit results,
// controller states and the 16-entry RGB palette used by the sprite path.
package brick_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY   = 2'd0,
    CELL_INTACT  = 2'd1,
    CELL_DAMAGED = 2'd2
  } cell_t;

  typedef enum logic [1:0] {
    RES_MISS      = 2'b00,
    RES_DAMAGED   = 2'b01,
    RES_DESTROYED = 2'b10
  } hit_res_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIT  = 2'd1,
    ST_LOAD = 2'd2
  } fsm_t;

  // Sprite index groups: brick shades step with texel row (ty[3:2]).
  localparam logic [3:0] PAL_MORTAR  = 4'd1;
  localparam logic [3:0] PAL_CRACK   = 4'd2;
  localparam logic [3:0] PAL_BRICK   = 4'd4;
  localparam logic [3:0] PAL_DAMAGED = 4'd8;

  localparam logic [23:0] PALETTE [16] = '{
    24'h000000, 24'h8C8C8C, 24'h2A1A10, 24'hFFFFFF,
    24'h9E2A1E, 24'hB23222, 24'hC43C28, 24'hD6482E,
    24'h6E3A2C, 24'h7E4232, 24'h8E4A38, 24'h9E523E,
    24'h203060, 24'h304080, 24'h4050A0, 24'hFFD700
  };

endpackage

// File: rtl/brick_sprite_rom.sv
// 512x4 brick sprite ROM with a registered (1-cycle) read.
// Address is {damaged, ty[3:0], tx[3:0]}; data is a palette index.
module brick_sprite_rom
  import brick_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] addr,
  output logic [3:0] data
);

  logic [3:0] tx;
  logic [3:0] ty;
  logic       dmg;
  logic [3:0] data_d;
  logic [3:0] data_q;

  assign tx  = addr[3:0];
  assign ty  = addr[7:4];
  assign dmg = addr[8];

  // Mortar on the top/left texel lines, diagonal cracks on damaged bricks.
  always_comb begin
    data_d = (dmg ? PAL_DAMAGED : PAL_BRICK) + {2'b00, ty[3:2]};
    if (tx == '0 || ty == '0) begin
      data_d = PAL_MORTAR;
    end else if (dmg && (tx == ty || tx == ~ty)) begin
      data_d = PAL_CRACK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/brick_field.sv
// Brick grid: per-cell damage state, a 2-stage sprite pixel pipeline and a
// small controller that serialises hit requests and full-grid restores.
module brick_field
  import brick_pkg::*;
#(
  parameter int unsigned          COLS      = 13,
  parameter int unsigned          ROWS      = 13,
  parameter int unsigned          GRID_X0   = 16,
  parameter int unsigned          GRID_Y0   = 16,
  parameter int unsigned          TILE_LOG2 = 5,
  parameter logic [COLS*ROWS-1:0] INIT_MAP  = '1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [7:0] Red_b,
  output logic [7:0] Green_b,
  output logic [7:0] Blue_b,
  output logic       brick_on,
  input  logic       hit_valid,
  input  logic [9:0] hit_x,
  input  logic [9:0] hit_y,
  output logic       hit_ready,
  output logic       hit_done,
  output logic [1:0] hit_result,
  input  logic       load_req,
  output logic       load_busy
);

  localparam int unsigned N_CELLS   = COLS * ROWS;
  localparam int unsigned IDX_W     = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
  localparam int unsigned GRID_W    = COLS << TILE_LOG2;
  localparam int unsigned GRID_H    = ROWS << TILE_LOG2;
  localparam int unsigned TILE_MASK = (1 << TILE_LOG2) - 1;
  localparam int unsigned TEX_SHIFT = TILE_LOG2 - 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);

  // Offsets wrap for coordinates left/above the grid, so a single unsigned
  // compare against the grid extent rejects both sides.
  function automatic logic [31:0] grid_off(input logic [9:0] v, input int unsigned base);
    return 32'(v) - base;
  endfunction

  function automatic logic [IDX_W-1:0] cell_index(input logic [31:0] ox, input logic [31:0] oy);
    return IDX_W'((oy >> TILE_LOG2) * COLS + (ox >> TILE_LOG2));
  endfunction

  function automatic logic [3:0] texel(input logic [31:0] o);
    return 4'((o & TILE_MASK) >> TEX_SHIFT);
  endfunction

  cell_t            cells_q [N_CELLS];
  cell_t            cells_d [N_CELLS];
  fsm_t             state_q, state_d;
  logic [9:0]       hx_q, hx_d;
  logic [9:0]       hy_q, hy_d;
  logic [IDX_W-1:0] load_cnt_q, load_cnt_d;
  logic             hit_done_q, hit_done_d;
  hit_res_t         hit_result_q, hit_result_d;

  cell_t            cell_s1_q, cell_s1_d;
  logic [3:0]       tx_s1_q, tx_s1_d;
  logic [3:0]       ty_s1_q, ty_s1_d;
  logic             brick_on_q, brick_on_d;
  logic [8:0]       rom_addr;
  logic [3:0]       rom_data;
  logic [23:0]      rgb;

  logic [31:0]      pix_ox, pix_oy, hit_ox, hit_oy;
  logic             pix_on, hit_on;
  logic [IDX_W-1:0] hit_idx;

  assign pix_ox  = grid_off(DrawX, GRID_X0);
  assign pix_oy  = grid_off(DrawY, GRID_Y0);
  assign pix_on  = (pix_ox < GRID_W) && (pix_oy < GRID_H);
  assign hit_ox  = grid_off(hx_q, GRID_X0);
  assign hit_oy  = grid_off(hy_q, GRID_Y0);
  assign hit_on  = (hit_ox < GRID_W) && (hit_oy < GRID_H);
  assign hit_idx = cell_index(hit_ox, hit_oy);

  always_comb begin
    cell_s1_d = CELL_EMPTY;
    if (pix_on) begin
      cell_s1_d = cells_q[cell_index(pix_ox, pix_oy)];
    end
    tx_s1_d    = texel(pix_ox);
    ty_s1_d    = texel(pix_oy);
    brick_on_d = (cell_s1_q != CELL_EMPTY);
    rom_addr   = {cell_s1_q == CELL_DAMAGED, ty_s1_q, tx_s1_q};
  end

  brick_sprite_rom u_rom (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .addr  (rom_addr),
    .data  (rom_data)
  );

  always_comb begin
    cells_d      = cells_q;
    state_d      = state_q;
    hx_d         = hx_q;
    hy_d         = hy_q;
    load_cnt_d   = load_cnt_q;
    hit_done_d   = 1'b0;
    hit_result_d = RES_MISS;
    case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          state_d    = ST_LOAD;
          load_cnt_d = '0;
        end else if (hit_valid) begin
          state_d = ST_HIT;
          hx_d    = hit_x;
          hy_d    = hit_y;
        end
      end
      ST_HIT: begin
        hit_done_d = 1'b1;
        state_d    = ST_IDLE;
        if (hit_on) begin
          case (cells_q[hit_idx])
            CELL_INTACT: begin
              cells_d[hit_idx] = CELL_DAMAGED;
              hit_result_d     = RES_DAMAGED;
            end
            CELL_DAMAGED: begin
              cells_d[hit_idx] = CELL_EMPTY;
              hit_result_d     = RES_DESTROYED;
            end
            default: hit_result_d = RES_MISS;
          endcase
        end
      end
      ST_LOAD: begin
        cells_d[load_cnt_q] = INIT_MAP[load_cnt_q] ? CELL_INTACT : CELL_EMPTY;
        if (load_cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_CELLS; i++) begin
        cells_q[i] <= INIT_MAP[i] ? CELL_INTACT : CELL_EMPTY;
      end
      state_q      <= ST_IDLE;
      hx_q         <= '0;
      hy_q         <= '0;
      load_cnt_q   <= '0;
      hit_done_q   <= 1'b0;
      hit_result_q <= RES_MISS;
      cell_s1_q    <= CELL_EMPTY;
      tx_s1_q      <= '0;
      ty_s1_q      <= '0;
      brick_on_q   <= 1'b0;
    end else begin
      cells_q      <= cells_d;
      state_q      <= state_d;
      hx_q         <= hx_d;
      hy_q         <= hy_d;
      load_cnt_q   <= load_cnt_d;
      hit_done_q   <= hit_done_d;
      hit_result_q <= hit_result_d;
      cell_s1_q    <= cell_s1_d;
      tx_s1_q      <= tx_s1_d;
      ty_s1_q      <= ty_s1_d;
      brick_on_q   <= brick_on_d;
    end
  end

  assign rgb        = brick_on_q ? PALETTE[rom_data] : '0;
  assign Red_b      = rgb[23:16];
  assign Green_b    = rgb[15:8];
  assign Blue_b     = rgb[7:0];
  assign brick_on   = brick_on_q;
  assign hit_ready  = (state_q == ST_IDLE) && !load_req;
  assign hit_done   = hit_done_q;
  assign hit_result = hit_result_q;
  assign load_busy  = (state_q == ST_LOAD);

endmodule
